// File: rtl/txuart.sv
// txuart: 8-bit LSB-first UART transmitter with optional parity and a
// one-deep holding register so consecutive frames leave no idle gap.
//
// Handshake: a byte is accepted on a rising edge where i_wr=1 and o_busy=0.
// o_busy reflects a full holding register. Writes made while o_busy=1 are
// dropped and leave the held byte untouched. The held byte moves into the
// shifter when the line is idle, or on the final stop-bit edge of the
// current frame.
module txuart #(
   parameter int   clk_frequency = 25000000,
   parameter int   baudRate      = 9600,
   parameter logic if_parity     = 1'b0,
   parameter logic parity_odd    = 1'b0
) (
   input  logic       i_clk,
   input  logic       rst,
   input  logic       i_wr,
   input  logic [7:0] i_data,
   output logic       o_uart_tx,
   output logic       o_busy,
   output logic       o_done
);

   localparam logic [15:0] clocksPerBaud = 16'(clk_frequency / baudRate);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic [2:0]  state;
   logic [15:0] baud_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shifter;
   logic [7:0]  hold;
   logic        hold_valid;
   logic        parity_bit;
   logic        bit_end;
   logic        wr_accept;
   logic        load;

   assign bit_end   = (baud_cnt == clocksPerBaud - 16'd1);
   assign wr_accept = i_wr && !hold_valid;
   // The held byte starts a new frame from idle, or directly off the last stop cycle.
   assign load      = hold_valid && ((state == IDLE) || ((state == STOP) && bit_end));
   assign o_busy    = hold_valid;
   // High during the final stop-bit cycle, i.e. the cycle ending on the completing edge.
   assign o_done    = (state == STOP) && bit_end;

   // Holding register data: captured only on an accepted write.
   always_ff @(posedge i_clk or posedge rst) begin
      if (rst) begin
         hold <= 8'h00;
      end else if (wr_accept) begin
         hold <= i_data;
      end
   end

   // Holding register flag: set by an accepted write, cleared when the shifter takes the byte.
   always_ff @(posedge i_clk or posedge rst) begin
      if (rst) begin
         hold_valid <= 1'b0;
      end else if (wr_accept) begin
         hold_valid <= 1'b1;
      end else if (load) begin
         hold_valid <= 1'b0;
      end
   end

   // Frame sequencer: baud timing, shifting and the registered serial line.
   always_ff @(posedge i_clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         baud_cnt   <= 16'd0;
         bit_idx    <= 3'd0;
         shifter    <= 8'h00;
         parity_bit <= 1'b0;
         o_uart_tx  <= 1'b1;
      end else if (load) begin
         state      <= START;
         baud_cnt   <= 16'd0;
         bit_idx    <= 3'd0;
         shifter    <= hold;
         parity_bit <= (^hold) ^ parity_odd;
         o_uart_tx  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               baud_cnt  <= 16'd0;
               o_uart_tx <= 1'b1;
            end
            START: begin
               if (bit_end) begin
                  state     <= DATA;
                  baud_cnt  <= 16'd0;
                  bit_idx   <= 3'd0;
                  o_uart_tx <= shifter[0];
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= 16'd0;
                  bit_idx  <= bit_idx + 3'd1;
                  shifter  <= {1'b0, shifter[7:1]};
                  if (bit_idx == 3'd7) begin
                     if (if_parity) begin
                        state     <= PARITY;
                        o_uart_tx <= parity_bit;
                     end else begin
                        state     <= STOP;
                        o_uart_tx <= 1'b1;
                     end
                  end else begin
                     o_uart_tx <= shifter[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            PARITY: begin
               if (bit_end) begin
                  state     <= STOP;
                  baud_cnt  <= 16'd0;
                  o_uart_tx <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  state     <= IDLE;
                  baud_cnt  <= 16'd0;
                  o_uart_tx <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            default: begin
               state     <= IDLE;
               baud_cnt  <= 16'd0;
               o_uart_tx <= 1'b1;
            end
         endcase
      end
   end

endmodule
